// File: rtl/usr_tx_sequencer.sv
// Serial transmitter that drives an external 8-bit universal shift register.
// Loads a byte into the USR, then shifts it out framed as start/8 data/stop.
module usr_tx_sequencer #(
    parameter int BAUD_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       lsb_first,
    output logic       in_ready,
    output logic [1:0] usr_sel,
    output logic [7:0] usr_datain,
    input  logic [7:0] usr_dataout,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic             order;
    logic             hs;
    logic             period_end;
    logic [2:0]       tx_idx;

    assign hs         = in_valid & in_ready;
    assign period_end = (baud_cnt == BAUD_LAST);
    // The line bit is whichever USR end the shift direction empties first
    assign tx_idx     = order ? 3'd0 : 3'd7;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            order      <= 1'b0;
            usr_datain <= 8'h00;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            if (hs) begin
                usr_datain <= in_data;
                order      <= lsb_first;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        tx        = 1'b1;
        usr_sel   = 2'b00;
        done      = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                baud_nxt = '0;
                bit_nxt  = '0;
                if (in_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                usr_sel   = 2'b11;
                baud_nxt  = '0;
                state_nxt = START;
            end
            START: begin
                tx = 1'b0;
                if (period_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                tx = usr_dataout[tx_idx];
                if (period_end) begin
                    usr_sel  = order ? 2'b01 : 2'b10;
                    baud_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (period_end) begin
                    done      = 1'b1;
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    baud_nxt = baud_cnt + BAUD_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usr_tx_sequencer.sv
// Bench for usr_tx_sequencer: two instances (BAUD_DIV 4 and 1), each
// wired to a behavioural USR, checked against directed and random frames.
module tb_usr_tx_sequencer;

    logic       clk;
    logic       Rst;
    logic       in_valid   [2];
    logic [7:0] in_data    [2];
    logic       lsb_first  [2];
    logic       in_ready   [2];
    logic [1:0] usr_sel    [2];
    logic [7:0] usr_datain [2];
    logic [7:0] usr_q      [2];
    logic       tx         [2];
    logic       busy       [2];
    logic       done       [2];

    int checks   = 0;
    int failures = 0;

    usr_tx_sequencer #(.BAUD_DIV(4), .CNT_W(8)) u_div4 (
        .clk        (clk),
        .Rst        (Rst),
        .in_valid   (in_valid[0]),
        .in_data    (in_data[0]),
        .lsb_first  (lsb_first[0]),
        .in_ready   (in_ready[0]),
        .usr_sel    (usr_sel[0]),
        .usr_datain (usr_datain[0]),
        .usr_dataout(usr_q[0]),
        .tx         (tx[0]),
        .busy       (busy[0]),
        .done       (done[0])
    );

    usr_tx_sequencer #(.BAUD_DIV(1), .CNT_W(8)) u_div1 (
        .clk        (clk),
        .Rst        (Rst),
        .in_valid   (in_valid[1]),
        .in_data    (in_data[1]),
        .lsb_first  (lsb_first[1]),
        .in_ready   (in_ready[1]),
        .usr_sel    (usr_sel[1]),
        .usr_datain (usr_datain[1]),
        .usr_dataout(usr_q[1]),
        .tx         (tx[1]),
        .busy       (busy[1]),
        .done       (done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Universal shift register seen by each sequencer
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            usr_q[0] <= 8'h00;
            usr_q[1] <= 8'h00;
        end else begin
            for (int g = 0; g < 2; g++) begin
                case (usr_sel[g])
                    2'b01:   usr_q[g] <= {usr_q[g][0], usr_q[g][7:1]};
                    2'b10:   usr_q[g] <= {usr_q[g][6:0], 1'b0};
                    2'b11:   usr_q[g] <= usr_datain[g];
                    default: usr_q[g] <= usr_q[g];
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Line as sent: start, data bits in the chosen order, stop
    function automatic logic [0:9] model_frame(input logic [7:0] d,
                                               input logic lsb);
        logic [0:9] f;
        f[0] = 1'b0;
        f[9] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = lsb ? d[i] : d[7-i];
        end
        return f;
    endfunction

    function automatic logic [7:0] model_final(input logic [7:0] d,
                                               input logic lsb);
        return lsb ? d : 8'h00;
    endfunction

    task automatic chk_idle(input int idx, input string tag);
        chk($sformatf("%s i%0d tx", tag, idx), tx[idx], 1);
        chk($sformatf("%s i%0d in_ready", tag, idx), in_ready[idx], 1);
        chk($sformatf("%s i%0d busy", tag, idx), busy[idx], 0);
        chk($sformatf("%s i%0d done", tag, idx), done[idx], 0);
        chk($sformatf("%s i%0d sel", tag, idx), usr_sel[idx], 0);
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle
    task automatic run_frame(input int idx, input logic [7:0] d,
                             input logic lsb, input logic [0:9] fr,
                             input logic [7:0] fin, input bit keep,
                             input bit expect_now);
        int div;
        int len;
        int n;
        int pulses;
        int k;
        int bitn;
        int ph;
        logic [1:0] code;
        logic [1:0] exp_sel;
        div    = (idx == 0) ? 4 : 1;
        len    = 1 + 10 * div;
        code   = lsb ? 2'b01 : 2'b10;
        pulses = 0;
        in_valid[idx]  = 1'b1;
        in_data[idx]   = d;
        lsb_first[idx] = lsb;
        n = 0;
        while (!in_ready[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("i%0d ready_wait", idx), in_ready[idx], 1);
        if (expect_now) begin
            chk($sformatf("i%0d b2b_gap", idx), n, 0);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin
            in_valid[idx] = 1'b0;
        end
        lsb_first[idx] = ~lsb;
        chk($sformatf("i%0d datain", idx), usr_datain[idx], d);
        for (int c = 0; c < len; c++) begin
            if (c == 0) begin
                chk($sformatf("i%0d c%0d tx", idx, c), tx[idx], 1);
                chk($sformatf("i%0d c%0d sel", idx, c), usr_sel[idx], 3);
            end else begin
                k    = c - 1;
                bitn = k / div;
                ph   = k % div;
                exp_sel = (bitn >= 1 && bitn <= 8 && ph == div - 1)
                          ? code : 2'b00;
                chk($sformatf("i%0d c%0d tx", idx, c), tx[idx], fr[bitn]);
                chk($sformatf("i%0d c%0d sel", idx, c), usr_sel[idx],
                    exp_sel);
            end
            chk($sformatf("i%0d c%0d done", idx, c), done[idx],
                (c == len - 1) ? 1 : 0);
            chk($sformatf("i%0d c%0d busy", idx, c), busy[idx], 1);
            chk($sformatf("i%0d c%0d in_ready", idx, c), in_ready[idx], 0);
            if (usr_sel[idx] == code) begin
                pulses++;
            end
            if (keep) begin
                in_data[idx] = 8'($urandom);
            end
            @(negedge clk);
        end
        chk($sformatf("i%0d shift_pulses", idx), pulses, 8);
        chk($sformatf("i%0d final_q", idx), usr_q[idx], fin);
        chk($sformatf("i%0d idle_tx", idx), tx[idx], 1);
        chk($sformatf("i%0d idle_ready", idx), in_ready[idx], 1);
        chk($sformatf("i%0d idle_busy", idx), busy[idx], 0);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       lsb;
        bit         keep;
        bit         b2b;
        logic [0:9] frame;
        logic [7:0] fin;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] rd;
        logic       rl;
        int         ri;

        vecs[0] = '{0, 8'h01, 1'b1, 1'b0, 1'b0, 10'b0100000001, 8'h01};
        vecs[1] = '{0, 8'h01, 1'b0, 1'b0, 1'b0, 10'b0000000011, 8'h00};
        vecs[2] = '{1, 8'h96, 1'b1, 1'b0, 1'b0, 10'b0011010011, 8'h96};
        vecs[3] = '{1, 8'h96, 1'b0, 1'b0, 1'b0, 10'b0100101101, 8'h00};
        vecs[4] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 10'b0101001011, 8'h00};
        vecs[5] = '{0, 8'h3C, 1'b1, 1'b0, 1'b1, 10'b0001111001, 8'h3C};

        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = 8'h00;
            lsb_first[i] = 1'b0;
        end
        Rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk_idle(i, "reset");
            chk($sformatf("reset i%0d datain", i), usr_datain[i], 0);
        end
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].inst, vecs[v].data, vecs[v].lsb,
                      vecs[v].frame, vecs[v].fin, vecs[v].keep,
                      vecs[v].b2b);
        end
        @(negedge clk);

        // Reset in the middle of data bit 3
        in_valid[0]  = 1'b1;
        in_data[0]   = 8'hA5;
        lsb_first[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("midrst pre_tx", tx[0], 0);
        chk("midrst pre_busy", busy[0], 1);
        #2;
        Rst = 1'b1;
        #1;
        chk_idle(0, "midrst");
        chk("midrst datain", usr_datain[0], 0);
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);
        run_frame(0, 8'hF0, 1'b1, 10'b0000011111, 8'hF0, 1'b0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            ri = int'($urandom_range(0, 1));
            rd = 8'($urandom);
            rl = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(ri, rd, rl, model_frame(rd, rl), model_final(rd, rl),
                      1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
